// File: rtl/st7920_serial_receiver.sv
// ST7920 3-wire serial receiver: oversamples lcd_clk/lcd_data and decodes sync + two nibble bytes.
// Optional idle timeout for partial frames is enabled by defining ST7920_RX_TIMEOUT_EN.
//
// state | meaning
// ------+-------------------------------------------------------------
// HUNT  | sliding 8-bit window searching for sync 11111,RW,RS,0
// HI    | shifting the high-nibble byte (nibble + 4 zero bits)
// LO    | shifting the low-nibble byte, then publish or discard frame
module st7920_serial_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n_ms,
  input  logic        lcd_clk,
  input  logic        lcd_data,
  output logic        rx_valid,
  output logic [7:0]  rx_byte,
  output logic        rx_rs,
  output logic        rx_rw,
  output logic        frame_err,
  output logic        busy,
  output logic [15:0] rx_count,
  output logic [7:0]  err_count
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {HUNT, HI, LO} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev;
  logic                   clk_s, data_s, bit_evt;
  logic [7:0]             sr, sr_n, shifted;
  logic [2:0]             bitcnt, bitcnt_n;
  logic [3:0]             hi, hi_n;
  logic                   hi_ok, hi_ok_n;
  logic                   f_rs, f_rs_n, f_rw, f_rw_n;
  logic                   rx_valid_n, frame_err_n;
  logic [7:0]             rx_byte_n;
  logic                   rx_rs_n, rx_rw_n;
  logic [15:0]            rx_count_n;
  logic [7:0]             err_count_n;
  logic                   timeout;

  assign clk_s   = clk_sync[SYNC_STAGES-1];
  assign data_s  = data_sync[SYNC_STAGES-1];
  assign bit_evt = clk_s & ~clk_prev;
  assign shifted = {sr[6:0], data_s};
  assign busy    = (state != HUNT);

`ifdef ST7920_RX_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [IDLE_W-1:0] idle_cnt, idle_cnt_n;

  // Counter only runs mid-frame; any bit event restarts the idle window.
  always_comb begin
    idle_cnt_n = '0;
    timeout    = 1'b0;
    if (state != HUNT && !bit_evt) begin
      if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
        timeout = 1'b1;
      end else begin
        idle_cnt_n = idle_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n_ms) begin
    if (!sys_rst_n_ms) idle_cnt <= '0;
    else               idle_cnt <= idle_cnt_n;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    sr_n        = sr;
    bitcnt_n    = bitcnt;
    hi_n        = hi;
    hi_ok_n     = hi_ok;
    f_rs_n      = f_rs;
    f_rw_n      = f_rw;
    rx_valid_n  = 1'b0;
    frame_err_n = 1'b0;
    rx_byte_n   = rx_byte;
    rx_rs_n     = rx_rs;
    rx_rw_n     = rx_rw;
    rx_count_n  = rx_count;
    err_count_n = err_count;

    if (timeout) begin
      state_n     = HUNT;
      sr_n        = 8'h00;
      bitcnt_n    = 3'd0;
      frame_err_n = 1'b1;
      if (err_count != 8'hFF) err_count_n = err_count + 8'd1;
    end else if (bit_evt) begin
      case (state)
        HUNT: begin
          sr_n = shifted;
          if (shifted[7:3] == 5'b11111 && !shifted[0]) begin
            f_rw_n   = shifted[2];
            f_rs_n   = shifted[1];
            bitcnt_n = 3'd0;
            state_n  = HI;
          end
        end
        HI: begin
          sr_n     = shifted;
          bitcnt_n = bitcnt + 3'd1;
          if (bitcnt == 3'd7) begin
            hi_n    = shifted[7:4];
            hi_ok_n = (shifted[3:0] == 4'h0);
            state_n = LO;
          end
        end
        LO: begin
          sr_n     = shifted;
          bitcnt_n = bitcnt + 3'd1;
          if (bitcnt == 3'd7) begin
            // Clearing the window keeps a frame's tail from aliasing into a sync.
            state_n = HUNT;
            sr_n    = 8'h00;
            if (hi_ok && shifted[3:0] == 4'h0) begin
              rx_valid_n = 1'b1;
              rx_byte_n  = {hi, shifted[7:4]};
              rx_rs_n    = f_rs;
              rx_rw_n    = f_rw;
              rx_count_n = rx_count + 16'd1;
            end else begin
              frame_err_n = 1'b1;
              if (err_count != 8'hFF) err_count_n = err_count + 8'd1;
            end
          end
        end
        default: begin
          state_n = HUNT;
          sr_n    = 8'h00;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n_ms) begin
    if (!sys_rst_n_ms) begin
      clk_sync  <= '0;
      data_sync <= '0;
      clk_prev  <= 1'b0;
      state     <= HUNT;
      sr        <= 8'h00;
      bitcnt    <= 3'd0;
      hi        <= 4'h0;
      hi_ok     <= 1'b0;
      f_rs      <= 1'b0;
      f_rw      <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_byte   <= 8'h00;
      rx_rs     <= 1'b0;
      rx_rw     <= 1'b0;
      rx_count  <= 16'h0000;
      err_count <= 8'h00;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], lcd_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], lcd_data};
      clk_prev  <= clk_s;
      state     <= state_n;
      sr        <= sr_n;
      bitcnt    <= bitcnt_n;
      hi        <= hi_n;
      hi_ok     <= hi_ok_n;
      f_rs      <= f_rs_n;
      f_rw      <= f_rw_n;
      rx_valid  <= rx_valid_n;
      frame_err <= frame_err_n;
      rx_byte   <= rx_byte_n;
      rx_rs     <= rx_rs_n;
      rx_rw     <= rx_rw_n;
      rx_count  <= rx_count_n;
      err_count <= err_count_n;
    end
  end

endmodule

// File: tb/tb_st7920_serial_receiver.sv
// Directed bench for st7920_serial_receiver: frames are serialised bit by bit, expected
// decodes are queued when a frame is sent and compared against the strobe it produces.
module tb_st7920_serial_receiver;

  localparam int SYNC  = 2;
  localparam int TMO   = 64;

  logic        sys_clk;
  logic        sys_rst_n_ms;
  logic        lcd_clk;
  logic        lcd_data;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_rs;
  logic        rx_rw;
  logic        frame_err;
  logic        busy;
  logic [15:0] rx_count;
  logic [7:0]  err_count;

  st7920_serial_receiver #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n_ms (sys_rst_n_ms),
    .lcd_clk      (lcd_clk),
    .lcd_data     (lcd_data),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .rx_rs        (rx_rs),
    .rx_rw        (rx_rw),
    .frame_err    (frame_err),
    .busy         (busy),
    .rx_count     (rx_count),
    .err_count    (err_count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       is_valid;
    logic [7:0] b;
    logic       rs;
    logic       rw;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          rise_cyc = 0;
  int          n_strobe = 0;
  int          obs_cyc = 0;
  logic        obs_valid, obs_err, obs_rs, obs_rw, both_seen;
  logic [7:0]  obs_byte;
  logic [7:0]  m_byte;
  logic        m_rs, m_rw;
  logic [15:0] m_rx_count;
  int          m_err_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    cyc++;
    if (rx_valid === 1'b1 || frame_err === 1'b1) begin
      n_strobe++;
      obs_valid = rx_valid;
      obs_err   = frame_err;
      obs_byte  = rx_byte;
      obs_rs    = rx_rs;
      obs_rw    = rx_rw;
      obs_cyc   = cyc;
      if (rx_valid === 1'b1 && frame_err === 1'b1) both_seen = 1'b1;
    end
  endtask

  task automatic send_bit(input logic b);
    lcd_data = b;
    repeat (3) tick();
    lcd_clk  = 1'b1;
    rise_cyc = cyc;
    repeat (3) tick();
    lcd_clk  = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] v, input int msb, input int lsb);
    logic [7:0] t;
    t = v;
    for (int i = msb; i >= lsb; i--) send_bit(t[i]);
  endtask

  // Reference decode: sync carries RW/RS, each payload byte is nibble + 4 zeros.
  task automatic push_expect(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    exp_t e;
    if (b1[3:0] == 4'h0 && b2[3:0] == 4'h0) begin
      m_byte = {b1[7:4], b2[7:4]};
      m_rs   = b0[1];
      m_rw   = b0[2];
      m_rx_count = m_rx_count + 16'd1;
      e.is_valid = 1'b1;
    end else begin
      if (m_err_count < 255) m_err_count++;
      e.is_valid = 1'b0;
    end
    e.b  = m_byte;
    e.rs = m_rs;
    e.rw = m_rw;
    sb.push_back(e);
  endtask

  task automatic check_frame(input string tag);
    exp_t e;
    e = sb.pop_front();
    chk({tag, "_strobes"}, n_strobe, 1);
    chk({tag, "_rx_valid"}, obs_valid, e.is_valid);
    chk({tag, "_frame_err"}, obs_err, !e.is_valid);
    chk({tag, "_rx_byte"}, obs_byte, e.b);
    chk({tag, "_rx_rs"}, obs_rs, e.rs);
    chk({tag, "_rx_rw"}, obs_rw, e.rw);
    chk({tag, "_latency"}, obs_cyc - rise_cyc, SYNC + 1);
    chk({tag, "_both"}, both_seen, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_rx_count"}, rx_count, m_rx_count);
    chk({tag, "_err_count"}, err_count, m_err_count);
    n_strobe = 0;
  endtask

  task automatic send_frame(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2);
    push_expect(b0, b1, b2);
    send_bits(b0, 7, 0);
    send_bits(b1, 7, 0);
    send_bits(b2, 7, 0);
    check_frame(tag);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rx_valid"}, rx_valid, 1'b0);
    chk({tag, "_frame_err"}, frame_err, 1'b0);
    chk({tag, "_rx_byte"}, rx_byte, 8'h00);
    chk({tag, "_rx_rs"}, rx_rs, 1'b0);
    chk({tag, "_rx_rw"}, rx_rw, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_rx_count"}, rx_count, 16'h0000);
    chk({tag, "_err_count"}, err_count, 8'h00);
  endtask

  task automatic model_reset();
    m_byte = 8'h00; m_rs = 1'b0; m_rw = 1'b0;
    m_rx_count = 16'h0000; m_err_count = 0;
  endtask

  initial begin
    int k;
    both_seen = 1'b0;
    obs_valid = 1'b0; obs_err = 1'b0; obs_rs = 1'b0; obs_rw = 1'b0; obs_byte = 8'h00;
    model_reset();
    sys_rst_n_ms = 1'b0;
    lcd_clk  = 1'b0;
    lcd_data = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    sys_rst_n_ms = 1'b1;
    repeat (2) tick();

    // Function set, instruction, write
    send_frame("t1_fset", 8'hF8, 8'h30, 8'h00);
    // Data write, decoded byte A5
    send_frame("t2_data", 8'hFA, 8'hA0, 8'h50);
    // Nonzero low bits in the high byte: discarded, outputs held
    send_frame("t3_bad", 8'hF8, 8'h31, 8'h00);
    send_frame("t3_zero", 8'hF8, 8'h00, 8'h00);

    // Leading junk bits ahead of a data frame
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    send_frame("t4_junk", 8'hFA, 8'h40, 8'h10);
    chk("t4_byte41", rx_byte, 8'h41);

    for (int i = 0; i < 256; i++) send_frame("t4_sat", 8'hF8, 8'h31, 8'h00);
    chk("t4_err_sat", err_count, 8'hFF);

    // Reset in the middle of a frame
    send_bits(8'hF8, 7, 0);
    send_bits(8'h30, 7, 4);
    sys_rst_n_ms = 1'b0;
    tick();
    check_all_zero("t5_in_reset");
    tick();
    sys_rst_n_ms = 1'b1;
    model_reset();
    repeat (2) tick();
    chk("t5_no_err", n_strobe, 0);
    send_frame("t5_after", 8'hF8, 8'h30, 8'h00);
    chk("t5_count", rx_count, 16'd1);

    // Stall after 10 bits
    send_bits(8'hF8, 7, 0);
    send_bits(8'h30, 7, 6);
`ifdef ST7920_RX_TIMEOUT_EN
    k = 0;
    while (n_strobe == 0 && k < 200) begin
      chk("t6_busy_wait", busy, 1'b1);
      tick();
      k++;
    end
    chk("t6_timeout_seen", n_strobe, 1);
    chk("t6_timeout_err", obs_err, 1'b1);
    chk("t6_timeout_window", (k >= 55 && k <= 75), 1'b1);
    tick();
    chk("t6_busy_after", busy, 1'b0);
    if (m_err_count < 255) m_err_count++;
    chk("t6_err_count", err_count, m_err_count);
    n_strobe = 0;
`else
    k = 0;
    repeat (200) begin
      tick();
      k++;
    end
    chk("t6_busy_hold", busy, 1'b1);
    chk("t6_no_strobe", n_strobe, 0);
    push_expect(8'hF8, 8'h30, 8'h00);
    send_bits(8'h30, 5, 0);
    send_bits(8'h00, 7, 0);
    check_frame("t6_resume");
`endif

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
